// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: length-prefixed image -> 32-bit word writes.
// Optional trailing 8-bit checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// S_IDLE  | waiting for start after reset
// S_LEN_HI| accepting length high byte
// S_LEN_LO| accepting length low byte, validating length
// S_DATA  | accepting image bytes into the assembly register
// S_WRITE | one-cycle word write strobe
// S_CHECK | accepting trailing checksum byte (checksum build only)
// S_DONE  | image loaded, processor released
// S_ERR   | bad length or checksum, processor held
module imem_loader #(
  parameter int                 A_WIDTH   = 32,
  parameter logic [A_WIDTH-1:0] BASE_ADDR = 32'hBFC00000,
  parameter int                 MAX_BYTES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_hi_q;
  logic [15:0] rem_q;
  logic [13:0] word_idx_q;
  logic [23:0] asm_q;
  logic [15:0] len_n;
  logic [31:0] len_ext;
  logic        len_bad;
  logic        last_of_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;
`endif

  assign len_n        = {len_hi_q, in_data};
  assign len_ext      = {16'd0, len_n};
  assign len_bad      = (len_ext > 32'(MAX_BYTES)) || (len_n[1:0] != 2'b00);
  // rem_q counts down remaining bytes; lengths are word multiples, so rem==1 mod 4 marks a word's last byte
  assign last_of_word = (rem_q[1:0] == 2'b01);

  assign mem_we   = (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign cpu_hold = (state_q != S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (len_n == 16'd0) state_d = S_DONE;
          else if (len_bad)   state_d = S_ERR;
          else                state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_of_word) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        if (rem_q != 16'd0) state_d = S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else state_d = S_CHECK;
`else
        else state_d = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi_q   <= 8'd0;
      rem_q      <= 16'd0;
      word_idx_q <= 14'd0;
      asm_q      <= 24'd0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            rem_q      <= 16'd0;
            word_idx_q <= 14'd0;
            asm_q      <= 24'd0;
          end
        end
        S_LEN_HI: if (in_valid) len_hi_q <= in_data;
        S_LEN_LO: if (in_valid) rem_q <= len_n;
        S_DATA: begin
          if (in_valid) begin
            asm_q <= {asm_q[15:0], in_data};
            rem_q <= rem_q - 16'd1;
            if (last_of_word) begin
              mem_addr  <= BASE_ADDR + A_WIDTH'({word_idx_q, 2'b00});
              mem_wdata <= {asm_q, in_data};
            end
          end
        end
        S_WRITE: word_idx_q <= word_idx_q + 14'd1;
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         sum_q <= 8'd0;
    else if (start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR))
                                                        sum_q <= 8'd0;
    else if (state_q == S_DATA && in_valid)             sum_q <= sum_q + in_data;
  end
`endif

endmodule
